// File: rtl/direction_queue.sv
// direction_queue: synchronizes and debounces the four player buttons,
// filters reversals/repeats and buffers accepted turns until the game tick.
module direction_queue #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPTH           = 2
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       TICK,
    input  logic       ISPAUSED,
    output logic       DIR_UP,
    output logic       DIR_DOWN,
    output logic       DIR_LEFT,
    output logic       DIR_RIGHT,
    output logic [2:0] PENDING,
    output logic       DROPPED
);

    // Direction vectors are {UP, DOWN, LEFT, RIGHT}; bit 3 has top priority.
    logic [3:0]         w_raw;
    logic [3:0]         r_btn_s1;
    logic [3:0]         r_btn_s2;
    logic [3:0]         r_db;
    logic [3:0]         r_db_d;
    logic [15:0]        r_cnt [4];
    logic               r_tick_s1;
    logic               r_tick_s2;
    logic               r_tick_q;
    logic               r_tick_edge;
    logic [3:0]         r_dir;
    logic [4*DEPTH-1:0] r_fifo;
    logic [2:0]         r_count;
    logic               r_dropped;

    logic [3:0]         w_rise;
    logic               w_pop;
    logic [2:0]         w_cnt_pp;
    logic [3:0]         w_dir_pp;
    logic [3:0]         w_tail;
    logic [3:0]         w_ref;
    logic [3:0]         w_opp;
    logic [3:0]         w_sel;
    logic               w_multi;
    logic               w_active;
    logic               w_same;
    logic               w_rev;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [4*DEPTH-1:0] w_fifo_nx;

    assign w_raw = {UP, DOWN, LEFT, RIGHT};

    // Two-flop synchronizers for buttons and tick, plus registered tick edge.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_btn_s1    <= '0;
            r_btn_s2    <= '0;
            r_tick_s1   <= 1'b0;
            r_tick_s2   <= 1'b0;
            r_tick_q    <= 1'b0;
            r_tick_edge <= 1'b0;
        end else begin
            r_btn_s1    <= w_raw;
            r_btn_s2    <= r_btn_s1;
            r_tick_s1   <= TICK;
            r_tick_s2   <= r_tick_s1;
            r_tick_q    <= r_tick_s2;
            r_tick_edge <= r_tick_s2 & ~r_tick_q;
        end
    end

    // Per-button debounce: level flips after DEBOUNCE_CYCLES steady disagreement.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_db   <= '0;
            r_db_d <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_db_d <= r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_btn_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == 16'(DEBOUNCE_CYCLES)) begin
                    r_db[i]  <= r_btn_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Post-pop view of the queue, used as reference for the incoming press.
    always_comb begin
        w_rise   = r_db & ~r_db_d;
        w_pop    = r_tick_edge & ~ISPAUSED & (r_count != 3'd0);
        w_cnt_pp = r_count - {2'b00, w_pop};
        w_dir_pp = w_pop ? r_fifo[3:0] : r_dir;
        w_tail   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(r_count) == i + 1) w_tail = r_fifo[4*i +: 4];
        end
        w_ref = (w_cnt_pp == 3'd0) ? w_dir_pp : w_tail;
        w_opp = {w_ref[2], w_ref[3], w_ref[0], w_ref[1]};
    end

    // Priority pick of the press and accept/reject decision.
    always_comb begin
        priority case (1'b1)
            w_rise[3]: w_sel = 4'b1000;
            w_rise[2]: w_sel = 4'b0100;
            w_rise[1]: w_sel = 4'b0010;
            w_rise[0]: w_sel = 4'b0001;
            default:   w_sel = 4'b0000;
        endcase
        w_multi  = |(w_rise & ~w_sel);
        w_active = ~ISPAUSED & (|w_rise);
        w_same   = (w_sel == w_ref);
        w_rev    = (|w_ref) & (w_sel == w_opp);
        w_full   = (w_cnt_pp == 3'(DEPTH));
        w_push   = w_active & ~w_same & ~w_rev & ~w_full;
        w_drop   = w_active & (w_multi | (~w_same & (w_rev | w_full)));
    end

    // Next FIFO image: shift out the head on pop, then append at the tail.
    always_comb begin
        w_fifo_nx = w_pop ? (r_fifo >> 4) : r_fifo;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (w_cnt_pp == 3'(i))) w_fifo_nx[4*i +: 4] = w_sel;
        end
    end

    // Direction register, queue storage, occupancy and drop pulse.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_dir     <= '0;
            r_fifo    <= '0;
            r_count   <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_dir     <= w_dir_pp;
            r_fifo    <= w_fifo_nx;
            r_count   <= w_cnt_pp + {2'b00, w_push};
            r_dropped <= w_drop;
        end
    end

    assign DIR_UP    = r_dir[3];
    assign DIR_DOWN  = r_dir[2];
    assign DIR_LEFT  = r_dir[1];
    assign DIR_RIGHT = r_dir[0];
    assign PENDING   = r_count;
    assign DROPPED   = r_dropped;

endmodule
